// File: rtl/async_fifo_param.sv
// Parametrised dual-clock FIFO, gray-pointer synchronised, with registered flags and counts.
// Define ASYNC_FIFO_FWFT_EN for first-word-fall-through reads; default is 1-cycle-latency reads.
module async_fifo_param #(
  parameter int DATA_WIDTH  = 8,
  parameter int ADDR_WIDTH  = 3,
  parameter int SYNC_STAGES = 2,
  parameter int AF_THRESH   = (1 << ADDR_WIDTH) - 2,
  parameter int AE_THRESH   = 1
) (
  input  logic                  wr_clk,
  input  logic                  wr_rst,
  input  logic                  rd_clk,
  input  logic                  rd_rst,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  full,
  output logic                  almost_full,
  output logic [ADDR_WIDTH:0]   wr_count,
  output logic                  overflow,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  empty,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   rd_count,
  output logic                  underflow
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int PW    = ADDR_WIDTH + 1;

  typedef logic [PW-1:0] ptr_t;

  localparam ptr_t AF_T = ptr_t'(AF_THRESH);
  localparam ptr_t AE_T = ptr_t'(AE_THRESH);

  function automatic ptr_t bin2gray(input ptr_t b);
    return b ^ (b >> 1);
  endfunction

  function automatic ptr_t gray2bin(input ptr_t g);
    ptr_t b;
    b = '0;
    for (int unsigned i = 0; i < PW; i++) b = b ^ (g >> i);
    return b;
  endfunction

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // ---------------- write domain ----------------
  ptr_t wr_bin, wr_gray;
  ptr_t rd_gray_ws [SYNC_STAGES];
  ptr_t rd_sync_w;
  ptr_t wr_bin_next, wr_gray_next, wr_count_next;
  logic wr_accept, full_next, almost_full_next;

  always_comb begin
    rd_sync_w        = rd_gray_ws[SYNC_STAGES-1];
    wr_accept        = wr_en && !full;
    wr_bin_next      = wr_bin + ptr_t'(wr_accept);
    wr_gray_next     = bin2gray(wr_bin_next);
    full_next        = (wr_gray_next == {~rd_sync_w[PW-1:PW-2], rd_sync_w[PW-3:0]});
    wr_count_next    = wr_bin_next - gray2bin(rd_sync_w);
    almost_full_next = (wr_count_next >= AF_T);
  end

  always_ff @(posedge wr_clk or posedge wr_rst) begin
    if (wr_rst) begin
      wr_bin      <= '0;
      wr_gray     <= '0;
      full        <= 1'b0;
      almost_full <= 1'b0;
      wr_count    <= '0;
      overflow    <= 1'b0;
      for (int unsigned i = 0; i < SYNC_STAGES; i++) rd_gray_ws[i] <= '0;
    end else begin
      wr_bin      <= wr_bin_next;
      wr_gray     <= wr_gray_next;
      full        <= full_next;
      almost_full <= almost_full_next;
      wr_count    <= wr_count_next;
      if (wr_en && full) overflow <= 1'b1;
      rd_gray_ws[0] <= rd_gray;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) rd_gray_ws[i] <= rd_gray_ws[i-1];
    end
  end

  always_ff @(posedge wr_clk) begin
    if (wr_accept) mem[wr_bin[ADDR_WIDTH-1:0]] <= wr_data;
  end

  // ---------------- read domain ----------------
  ptr_t rd_bin, rd_gray;
  ptr_t wr_gray_rs [SYNC_STAGES];
  ptr_t wr_sync_r;
  ptr_t rd_bin_next, rd_gray_next, rd_count_next;
  logic rd_load, rd_valid_next, empty_next, almost_empty_next;

  always_comb begin
    wr_sync_r = wr_gray_rs[SYNC_STAGES-1];
`ifdef ASYNC_FIFO_FWFT_EN
    // Output register acts as an extra slot: refill whenever it is free or being popped,
    // judged directly on the synced pointer so the head appears one edge after it is visible.
    rd_load       = (rd_gray != wr_sync_r) && (!rd_valid || rd_en);
    rd_valid_next = rd_load || (rd_valid && !rd_en);
    rd_bin_next   = rd_bin + ptr_t'(rd_load);
    rd_gray_next  = bin2gray(rd_bin_next);
    empty_next    = !rd_valid_next;
    rd_count_next = gray2bin(wr_sync_r) - rd_bin_next + ptr_t'(rd_valid_next);
`else
    rd_load       = rd_en && !empty;
    rd_valid_next = rd_load;
    rd_bin_next   = rd_bin + ptr_t'(rd_load);
    rd_gray_next  = bin2gray(rd_bin_next);
    empty_next    = (rd_gray_next == wr_sync_r);
    rd_count_next = gray2bin(wr_sync_r) - rd_bin_next;
`endif
    almost_empty_next = (rd_count_next <= AE_T);
  end

  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      rd_bin       <= '0;
      rd_gray      <= '0;
      empty        <= 1'b1;
      almost_empty <= 1'b1;
      rd_count     <= '0;
      rd_data      <= '0;
      rd_valid     <= 1'b0;
      underflow    <= 1'b0;
      for (int unsigned i = 0; i < SYNC_STAGES; i++) wr_gray_rs[i] <= '0;
    end else begin
      rd_bin       <= rd_bin_next;
      rd_gray      <= rd_gray_next;
      empty        <= empty_next;
      almost_empty <= almost_empty_next;
      rd_count     <= rd_count_next;
      rd_valid     <= rd_valid_next;
      if (rd_load) rd_data <= mem[rd_bin[ADDR_WIDTH-1:0]];
      if (rd_en && empty) underflow <= 1'b1;
      wr_gray_rs[0] <= wr_gray;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) wr_gray_rs[i] <= wr_gray_rs[i-1];
    end
  end

endmodule

// File: tb/tb_async_fifo_param.sv
// Directed bench for async_fifo_param: reset, fill, overflow, drain, underflow,
// random concurrent traffic across pointer wraps, joint reset, and the FWFT build.
module tb_async_fifo_param;

  logic       wr_clk = 1'b0, rd_clk = 1'b0;
  logic       wr_rst, rd_rst, wr_en, rd_en;
  logic [7:0] wr_data, rd_data;
  logic       full, almost_full, overflow, rd_valid, empty, almost_empty, underflow;
  logic [3:0] wr_count, rd_count;

  int checks = 0;
  int errors = 0;

  logic [7:0] q[$];

  async_fifo_param #(
    .DATA_WIDTH(8), .ADDR_WIDTH(3), .SYNC_STAGES(2), .AF_THRESH(6), .AE_THRESH(1)
  ) dut (
    .wr_clk(wr_clk), .wr_rst(wr_rst), .rd_clk(rd_clk), .rd_rst(rd_rst),
    .wr_en(wr_en), .wr_data(wr_data), .full(full), .almost_full(almost_full),
    .wr_count(wr_count), .overflow(overflow),
    .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid), .empty(empty),
    .almost_empty(almost_empty), .rd_count(rd_count), .underflow(underflow)
  );

  always #5 wr_clk = ~wr_clk;
  always begin
    #18 rd_clk = 1'b1;
    #19 rd_clk = 1'b0;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic reset_both();
    wr_rst = 1'b1; rd_rst = 1'b1;
    wr_en = 1'b0; rd_en = 1'b0; wr_data = '0;
    repeat (3) @(posedge rd_clk);
    @(posedge wr_clk); #1;
    wr_rst = 1'b0; rd_rst = 1'b0;
    #1;
  endtask

  initial begin
    reset_both();
    check("rst_full", full, 0);
    check("rst_almost_full", almost_full, 0);
    check("rst_wr_count", wr_count, 0);
    check("rst_overflow", overflow, 0);
    check("rst_empty", empty, 1);
    check("rst_almost_empty", almost_empty, 1);
    check("rst_rd_count", rd_count, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_rd_data", rd_data, 8'h00);
    check("rst_underflow", underflow, 0);

`ifdef ASYNC_FIFO_FWFT_EN
    begin
      int unsigned n;
      logic seen;
      wr_en = 1'b1; wr_data = 8'hA5;
      @(posedge wr_clk); #1;
      wr_en = 1'b0;
      n = 0; seen = 1'b0;
      for (int unsigned k = 0; k < 4 && !seen; k++) begin
        @(posedge rd_clk); #1;
        n++;
        seen = rd_valid;
      end
      check("fwft_head_within_4", seen, 1);
      check("fwft_head_data", rd_data, 8'hA5);
      check("fwft_not_empty", empty, 0);
      check("fwft_rd_count", rd_count, 1);
      rd_en = 1'b1;
      @(posedge rd_clk); #1;
      rd_en = 1'b0;
      check("fwft_pop_valid", rd_valid, 0);
      check("fwft_pop_empty", empty, 1);
      check("fwft_pop_underflow", underflow, 0);
      check("fwft_pop_rd_count", rd_count, 0);
    end
`else
    // Fill with the read side idle: read pointer stays 0, so counts track writes exactly.
    for (int i = 0; i < 8; i++) begin
      wr_en = 1'b1; wr_data = 8'h10 + 8'(i);
      @(posedge wr_clk); #1;
      check("fill_wr_count", wr_count, i + 1);
      check("fill_almost_full", almost_full, (i + 1 >= 6) ? 1 : 0);
      check("fill_full", full, (i == 7) ? 1 : 0);
    end
    wr_en = 1'b1; wr_data = 8'h99;
    @(posedge wr_clk); #1;
    wr_en = 1'b0;
    check("ovf_overflow", overflow, 1);
    check("ovf_full", full, 1);
    check("ovf_wr_count", wr_count, 8);

    repeat (6) @(posedge rd_clk); #1;
    check("sync_rd_count", rd_count, 8);
    check("sync_empty", empty, 0);
    check("sync_almost_empty", almost_empty, 0);

    rd_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge rd_clk); #1;
      check("drain_data", rd_data, 8'h10 + 8'(i));
      check("drain_valid", rd_valid, 1);
      check("drain_empty", empty, (i == 7) ? 1 : 0);
      check("drain_rd_count", rd_count, 7 - i);
      check("drain_almost_empty", almost_empty, (7 - i <= 1) ? 1 : 0);
    end
    @(posedge rd_clk); #1;
    rd_en = 1'b0;
    check("udf_underflow", underflow, 1);
    check("udf_valid", rd_valid, 0);
    check("udf_data_held", rd_data, 8'h17);
    check("udf_empty", empty, 1);

    repeat (8) @(posedge wr_clk); #1;
    check("freed_full", full, 0);
    check("freed_wr_count", wr_count, 0);
    check("freed_almost_full", almost_full, 0);
    check("freed_overflow_sticky", overflow, 1);

    // Random concurrent traffic; 50 words move the 4-bit pointers through more than 3 wraps.
    fork
      begin : writer
        int unsigned sent = 0, cyc = 0;
        while (sent < 50 && cyc < 3000) begin
          @(posedge wr_clk); #1;
          wr_en   = ($urandom_range(0, 1) == 1);
          wr_data = 8'($urandom);
          if (wr_en && !full) begin
            q.push_back(wr_data);
            sent++;
          end
          cyc++;
        end
        @(posedge wr_clk); #1;
        wr_en = 1'b0;
        check("rand_all_written", sent, 50);
      end
      begin : reader
        int unsigned got = 0, rc = 0;
        logic exp_v = 1'b0;
        while (got < 50 && rc < 3000) begin
          @(posedge rd_clk); #1;
          check("rand_rd_valid", rd_valid, exp_v);
          if (rd_valid) begin
            check("rand_not_ahead", (q.size() != 0), 1);
            if (q.size() != 0) check("rand_order", rd_data, q.pop_front());
            got++;
          end
          rd_en = ($urandom_range(0, 1) == 1);
          exp_v = rd_en && !empty;
          rc++;
        end
        rd_en = 1'b0;
        check("rand_all_read", got, 50);
      end
    join

    repeat (6) @(posedge rd_clk); #1;
    check("post_rand_empty", empty, 1);
    check("post_rand_rd_count", rd_count, 0);
    check("post_rand_queue", q.size(), 0);
    check("post_rand_wr_count", wr_count, 0);

    // Joint reset with data in flight discards contents and clears sticky errors.
    for (int i = 0; i < 3; i++) begin
      wr_en = 1'b1; wr_data = 8'hC0 + 8'(i);
      @(posedge wr_clk); #1;
    end
    wr_en = 1'b0;
    reset_both();
    check("rrst_overflow", overflow, 0);
    check("rrst_underflow", underflow, 0);
    check("rrst_wr_count", wr_count, 0);
    repeat (6) @(posedge rd_clk); #1;
    check("rrst_empty", empty, 1);
    check("rrst_rd_count", rd_count, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/async_fifo_param.md
Name: async_fifo_param

Overview:
Parametrised dual-clock FIFO for crossing data from the wr_clk domain to an independent rd_clk domain.
- Generalises the current 4-bit x 8-entry async FIFO in data width, depth and synchroniser depth.
- Adds registered flags, per-domain fill counts, programmable almost-full/almost-empty thresholds, sticky overflow/underflow error flags, and an optional first-word-fall-through (FWFT) read mode.
- Sits between a fast write-side producer and a slower divided-clock consumer.

Parameters:
DATA_WIDTH, 8, width of each stored word in bits (1..32)
ADDR_WIDTH, 3, log2 of depth; DEPTH = 2**ADDR_WIDTH (2..6)
SYNC_STAGES, 2, flops per gray-pointer synchroniser chain (2..4)
AF_THRESH, DEPTH-2, almost_full asserts when wr_count >= AF_THRESH (1..DEPTH)
AE_THRESH, 1, almost_empty asserts when rd_count <= AE_THRESH (0..DEPTH-1)

Ports:
wr_clk  in  1  write clock
wr_rst  in  1  write-domain reset; asynchronous, active-high
rd_clk  in  1  read clock, asynchronous to wr_clk
rd_rst  in  1  read-domain reset; asynchronous, active-high
wr_en  in  1  write request
wr_data  in  DATA_WIDTH  write word
full  out  1  no free slot (wr_clk domain)
almost_full  out  1  wr_count >= AF_THRESH
wr_count  out  ADDR_WIDTH+1  write-side view of occupancy
overflow  out  1  sticky: write attempted while full
rd_en  in  1  read request / pop
rd_data  out  DATA_WIDTH  read word
rd_valid  out  1  rd_data holds a valid word
empty  out  1  no readable word (rd_clk domain)
almost_empty  out  1  rd_count <= AE_THRESH
rd_count  out  ADDR_WIDTH+1  read-side view of occupancy
underflow  out  1  sticky: read attempted while empty

Behaviour:
- Pointers: binary plus registered gray copy, ADDR_WIDTH+1 bits; memory indexed by the low ADDR_WIDTH bits; wrap is modulo 2*DEPTH.
- Each gray pointer crosses domains through a SYNC_STAGES-flop chain clocked by the destination clock. No binary value ever crosses.
- Write accepted iff wr_en && !full: mem[wr_ptr] <= wr_data, wr_ptr increments.
- Registered full: computed from the next wr gray pointer vs the synced rd gray pointer (top two bits inverted, rest equal). Full rises on the same wr_clk edge that writes the last free slot.
- Registered empty: computed from the next rd gray pointer vs the synced wr gray pointer. Empty rises on the edge that pops the last word.
- Counts: wr_count = wr_ptr - gray2bin(rd_sync); rd_count = gray2bin(wr_sync) - rd_ptr. Both are registered, ADDR_WIDTH+1 bits, and range 0..DEPTH.
- Conservatism: counts and flags in each domain are pessimistic. Full, almost_full and wr_count may lag frees by up to SYNC_STAGES+1 wr_clk cycles; empty, almost_empty and rd_count may lag writes by up to SYNC_STAGES+1 rd_clk cycles. Full is never late on a write; empty is never late on a read.
- Write-to-read latency: a written word becomes readable at most SYNC_STAGES+2 rd_clk edges after the write edge.
- Standard mode read: when rd_en && !empty, rd_data <= mem[rd_ptr] and rd_valid <= 1 on that edge (1-cycle latency), and rd_ptr increments. Otherwise rd_valid <= 0 and rd_data holds its value.
- Errors (ignored requests, pointers unchanged):
  - wr_en && full sets overflow; it is cleared only by wr_rst.
  - rd_en && empty sets underflow; it is cleared only by rd_rst.
- Simultaneous write and read on a full or empty FIFO: each side is judged only by its own flag. A write while full is rejected even if a read happens in the same real time.
- Reset values:
  - Write domain (wr_rst): wr pointers 0, write-side sync chain 0, full 0, almost_full 0, wr_count 0, overflow 0.
  - Read domain (rd_rst): rd pointers 0, read-side sync chain 0, empty 1, almost_empty 1, rd_count 0, rd_data 0, rd_valid 0, underflow 0.
  - Memory contents are not reset.
- Reset mid-operation: wr_rst and rd_rst must overlap for at least one edge of each clock. The FIFO is then empty and all stored data is discarded. A reset of one domain alone is unsupported and the bench must not do it.

Optional Feature:
ASYNC_FIFO_FWFT_EN
- Defined: first-word-fall-through mode.
  - The head word is presented on rd_data with rd_valid=1 whenever the FIFO holds data, without rd_en; the head appears at most 1 rd_clk after empty would deassert.
  - rd_en while rd_valid=1 pops the head, and the next word or rd_valid=0 appears on the following edge.
  - empty = !rd_valid.
  - rd_count includes the presented word.
  - underflow = rd_en && !rd_valid.
- Undefined: standard 1-cycle-latency mode as above.

Test Plan:
All scenarios use DATA_WIDTH=8, ADDR_WIDTH=3, SYNC_STAGES=2, AF_THRESH=6, AE_THRESH=1, wr_clk 10 ns, rd_clk 37 ns.
- Reset: assert both resets, release -> full=0, empty=1, almost_empty=1, counts=0, rd_valid=0, rd_data=0x00.
- Fill: write 0x10..0x17 with rd_en=0 -> almost_full rises on the write of 0x15 (wr_count=6); full rises on the edge writing 0x17; wr_count=8.
- Overflow: extra write 0x99 while full -> overflow=1; a later drain returns exactly 0x10..0x17 and never 0x99.
- Drain: rd_en held high -> 0x10..0x17 in order with rd_valid each cycle; empty rises on the 8th pop. A further rd_en sets underflow=1 and rd_data stays 0x17.
- Wrap and concurrency: 50 random words, both sides enabled at random -> read order equals write order across more than 3 pointer wraps; never full && wr accepted, never empty && rd accepted.
- FWFT build: write 0xA5 -> rd_valid=1 and rd_data=0xA5 within 4 rd_clk with no rd_en; one rd_en -> rd_valid=0, empty=1.
